// File: rtl/gpu_instr_scheduler.sv
// Two-requester instruction scheduler: per-requester FIFOs, round-robin pick, opcode filter, cooldown.
// Strobe lands two cycles after the push edge; ready drops only on full FIFOs, i_hold stalls issue only.

module sched_fifo #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_vld,
  input  logic [31:0] in_dat,
  output logic        in_rdy,
  input  logic        pop,
  output logic [31:0] head_dat,
  output logic        not_empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign in_rdy    = count < FULL;
  assign not_empty = count != '0;
  assign do_push   = in_vld && in_rdy;
  assign do_pop    = pop && not_empty;
  assign head_dat  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= in_dat;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      count <= count + (AW+1)'(1);
      else if (!do_push && do_pop) count <= count - (AW+1)'(1);
    end
  end
endmodule

module gpu_instr_scheduler #(
  parameter int FIFO_DEPTH = 4,
  parameter int BASE_GAP   = 1,
  parameter int SPRITE_GAP = 8
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_valid0,
  input  logic [31:0] i_instr0,
  output logic        o_ready0,
  input  logic        i_valid1,
  input  logic [31:0] i_instr1,
  output logic        o_ready1,
  input  logic        i_hold,
  output logic [31:0] o_instruction,
  output logic        o_instruction_ready,
  output logic        o_busy,
  output logic [7:0]  o_drop_count
);
  typedef enum logic [1:0] {IDLE, ISSUE, COOLDOWN} state_t;

  localparam logic [3:0] BASE_G   = 4'(BASE_GAP);
  localparam logic [3:0] SPRITE_G = 4'(SPRITE_GAP);

  state_t      state;
  logic [3:0]  cnt;
  logic        last_grant;
  logic        is_sprite;
  logic        ne0, ne1;
  logic [31:0] head0, head1, head;
  logic        sel;
  logic        pop_en;
  logic [3:0]  opcode;
  logic        op_ok;
  logic [3:0]  gap_load;

  sched_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo0 (
    .clk(i_clk), .rst_n(i_reset_n),
    .in_vld(i_valid0), .in_dat(i_instr0), .in_rdy(o_ready0),
    .pop(pop_en && !sel), .head_dat(head0), .not_empty(ne0)
  );

  sched_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo1 (
    .clk(i_clk), .rst_n(i_reset_n),
    .in_vld(i_valid1), .in_dat(i_instr1), .in_rdy(o_ready1),
    .pop(pop_en && sel), .head_dat(head1), .not_empty(ne1)
  );

  // With both queues waiting, grant the one not served last; otherwise whichever has data.
  assign sel      = (ne0 && ne1) ? ~last_grant : ne1;
  assign head     = sel ? head1 : head0;
  assign opcode   = head[3:0];
  assign op_ok    = (opcode >= 4'd1) && (opcode <= 4'd8);
  assign pop_en   = (state == IDLE) && !i_hold && (ne0 || ne1);
  assign gap_load = is_sprite ? SPRITE_G : BASE_G;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state               <= IDLE;
      cnt                 <= '0;
      last_grant          <= 1'b1;
      is_sprite           <= 1'b0;
      o_instruction       <= '0;
      o_instruction_ready <= 1'b0;
      o_busy              <= 1'b0;
      o_drop_count        <= '0;
    end else begin
      o_instruction_ready <= 1'b0;
      o_busy              <= (state != IDLE) || ne0 || ne1;
      case (state)
        IDLE: begin
          if (pop_en) begin
            if (op_ok) begin
              o_instruction <= head;
              last_grant    <= sel;
              is_sprite     <= (opcode == 4'd8);
              state         <= ISSUE;
            end else if (o_drop_count != 8'hFF) begin
              o_drop_count <= o_drop_count + 8'd1;
            end
          end
        end
        ISSUE: begin
          o_instruction_ready <= 1'b1;
          cnt                 <= gap_load;
          state               <= (gap_load == 4'd0) ? IDLE : COOLDOWN;
        end
        COOLDOWN: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/gpu_instr_scheduler.md
GPU_INSTR_SCHEDULER -- requirements
Module: gpu_instr_scheduler

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, meaning entries per requester FIFO (power of two, 2..16).
REQ-002 SHALL have parameter BASE_GAP, default 1, meaning cooldown cycles after any non-sprite instruction (0..15).
REQ-003 SHALL have parameter SPRITE_GAP, default 8, meaning cooldown cycles after a SET_SPRITE instruction (0..15).
REQ-004 SHALL have port i_clk, input, 1, meaning the single clock; all logic is on its rising edge.
REQ-005 SHALL have port i_reset_n, input, 1, meaning asynchronous active-low reset.
REQ-006 SHALL have ports i_valid0 and i_valid1, input, 1 each, meaning requester k presents an instruction.
REQ-007 SHALL have ports i_instr0 and i_instr1, input, 32 each, meaning requester k instruction word; opcode is bits [3:0].
REQ-008 SHALL have ports o_ready0 and o_ready1, output, 1 each, meaning requester k FIFO can accept.
REQ-009 SHALL have port i_hold, input, 1, meaning inhibit new issue (screen reset or vsync window).
REQ-010 SHALL have port o_instruction, output, 32, meaning the issued instruction word to the pixel generator.
REQ-011 SHALL have port o_instruction_ready, output, 1, meaning a one-cycle issue strobe.
REQ-012 SHALL have port o_busy, output, 1, meaning state is not IDLE or either FIFO is non-empty.
REQ-013 SHALL have port o_drop_count, output, 8, meaning saturating count of discarded invalid opcodes.

Function
REQ-014 SHALL accept a push on requester k when i_validk and o_readyk are both high at a clock edge.
REQ-015 SHALL drive o_readyk from registered FIFO occupancy only, high iff occupancy < FIFO_DEPTH, with no combinational path from any input.
REQ-016 SHALL allow a push and a pop on the same FIFO in one cycle, leaving occupancy unchanged and preserving order.
REQ-017 SHALL implement three states: IDLE, ISSUE and COOLDOWN.
REQ-018 SHALL, in IDLE with i_hold low and at least one FIFO non-empty, select a requester, pop its head and register it.
REQ-019 SHALL select round-robin: when both FIFOs are non-empty, the requester not granted last; after reset, requester 0 first.
REQ-020 SHALL, for a popped opcode of 1..8, register o_instruction and go to ISSUE, where o_instruction_ready is high for exactly one cycle.
REQ-021 SHALL, for a popped opcode of 0 or 9..15, discard the word, increment o_drop_count (saturating at 255), stay in IDLE, and not change the round-robin pointer.
REQ-022 SHALL, in ISSUE, load the cooldown counter with SPRITE_GAP if the opcode is 8, else BASE_GAP; go to IDLE if the loaded value is 0, else to COOLDOWN.
REQ-023 SHALL, in COOLDOWN, decrement the counter each cycle and go to IDLE on the cycle the counter equals 1.
REQ-024 SHALL make consecutive strobes at least GAP+2 cycles apart, where GAP is the value loaded after the first strobe; for example, strobes at cycle N and N+10 after SET_SPRITE with SPRITE_GAP=8.
REQ-025 SHALL hold o_instruction stable from the strobe until the next issue, and need not zero it between strobes.
REQ-026 SHALL let i_hold block only the IDLE selection: cooldown keeps counting and pushes are still accepted.
REQ-027 SHALL not corrupt occupancy or pointers when a FIFO is full, and treat pop on an empty FIFO as impossible (selection requires non-empty).
REQ-028 SHALL use wrap-around pointers of log2(FIFO_DEPTH) bits and an occupancy counter of log2(FIFO_DEPTH)+1 bits.

Reset
REQ-029 SHALL, while i_reset_n is low, asynchronously force: state IDLE; both FIFOs empty; o_ready0 and o_ready1 = 1; o_instruction = 0; o_instruction_ready = 0; o_busy = 0; o_drop_count = 0; cooldown counter = 0; round-robin favouring requester 0.
REQ-030 SHALL, on reset assertion mid-ISSUE or mid-COOLDOWN, drop the strobe immediately, discard queued words, and issue nothing from before reset after release.

Verification
REQ-031 SHALL be verified as: one push of 32'h0000_0F01 on requester 0 from idle -> strobe 2 cycles after the push edge, o_instruction = 32'h0000_0F01, o_busy low 2 cycles later (BASE_GAP=1).
REQ-032 SHALL be verified as: SET_SPRITE 32'h0AB3_2108 then SET_PIXEL 32'h0105_0007, both on requester 1 -> strobes exactly 10 cycles apart (SPRITE_GAP=8).
REQ-033 SHALL be verified as: both FIFOs filled with 4 words each (A0..A3, B0..B3) -> issue order A0,B0,A1,B1,A2,B2,A3,B3; o_ready low when full; a 5th push is ignored.
REQ-034 SHALL be verified as: opcodes 0x0, 0xC, 0x5 pushed on requester 0 -> only 0x5 issued; o_drop_count = 2; 300 invalid pushes -> o_drop_count = 255.
REQ-035 SHALL be verified as: i_hold high with 2 queued words -> no strobe, pushes still accepted; i_hold low -> first strobe 2 cycles later.
REQ-036 SHALL be verified as: reset pulsed during COOLDOWN with 3 queued words -> strobe and o_busy low immediately, both o_ready high, no strobe after release.
